op_dispatcher: RTL and testbench

Sequences opcodes from the parser/op FIFO into the opcode handlers. It accepts one `Op_st` at a time and holds it stable on `cur_op`, which drives the handler input chooser. It then pulses the handler trigger, waits for completion, and only then accepts the next opcode. It also provides a watchdog, pause control and a completed-op counter for status readout.

---
 rtl/op_dispatcher_pkg.sv | 29 ++
 rtl/op_dispatcher_watchdog.sv | 30 +++
 rtl/op_dispatcher.sv | 125 ++++++++++++
 tb/tb_op_dispatcher.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_dispatcher_pkg.sv
// Shared opcode payload, command codes and dispatcher state type for the op
// pipeline (parser FIFO -> dispatcher -> handler chooser).
package op_dispatcher_pkg;

   localparam int unsigned OP_CMD_W = 8;
   localparam int unsigned OP_ARG_W = 24;
   localparam int unsigned WD_W     = 32;

   localparam logic [OP_CMD_W-1:0] OP_CMD_G00 = 8'h00;
   localparam logic [OP_CMD_W-1:0] OP_CMD_G01 = 8'h01;
   localparam logic [OP_CMD_W-1:0] OP_CMD_G02 = 8'h02;
   localparam logic [OP_CMD_W-1:0] OP_CMD_G03 = 8'h03;
   localparam logic [OP_CMD_W-1:0] OP_CMD_M02 = 8'h82;

   typedef struct packed {
      logic [OP_CMD_W-1:0] cmd;
      logic [OP_ARG_W-1:0] arg;
   } Op_st;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_RDY,
      ST_TRIGGER,
      ST_WAIT_DONE,
      ST_ERROR
   } OpDispatchState_t;

endpackage

// File: rtl/op_dispatcher_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT_CYCLES-th enabled cycle (0 disables it).
module op_watchdog
   import op_dispatcher_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired_c
);

   localparam logic [WD_W-1:0] LIMIT_M1 = WD_W'(TIMEOUT_CYCLES - 32'd1);

   logic [WD_W-1:0] r_count;

   // Saturating so a disabled watchdog never wraps back into range.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + WD_W'(1);
      end
   end

   assign o_expired_c = (TIMEOUT_CYCLES != 32'd0) && i_enable && (r_count >= LIMIT_M1);

endmodule

// File: rtl/op_dispatcher.sv
// Op dispatcher: accepts one op at a time, holds it on cur_op for the handler
// chooser, pulses the trigger, waits for done, with watchdog and pause.
module op_dispatcher
   import op_dispatcher_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd16777216,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  Op_st             op_in,
   input  logic             op_in_valid,
   output logic             op_in_rdy,
   input  logic             pause,
   output Op_st             cur_op,
   output logic             handler_trigger,
   input  logic             handler_rdy,
   input  logic             handler_done,
   output logic             busy,
   output logic             err_timeout,
   input  logic             clear_err,
   output logic [CNT_W-1:0] ops_done
);

   OpDispatchState_t r_state;
   Op_st             r_cur_op;
   logic             r_trigger;
   logic             r_busy;
   logic             r_err;
   logic [CNT_W-1:0] r_ops;

   logic w_wd_clear;
   logic w_wd_en;
   logic w_wd_expired;

   assign w_wd_clear = (r_state == ST_LOAD);
   assign w_wd_en    = (r_state == ST_WAIT_RDY) || (r_state == ST_TRIGGER) ||
                       (r_state == ST_WAIT_DONE);

   op_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_wd_clear),
      .i_enable   (w_wd_en),
      .o_expired_c(w_wd_expired)
   );

   // Only the acceptance handshake is combinational, so the FIFO sees pause at once.
   assign op_in_rdy = (r_state == ST_IDLE) && !pause;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cur_op  <= '0;
         r_trigger <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_ops     <= '0;
      end else begin
         r_trigger <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (op_in_valid && op_in_rdy) begin
                  r_cur_op <= op_in;
                  r_busy   <= 1'b1;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_state <= ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
               if (w_wd_expired) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_ERROR;
               end else if (handler_rdy) begin
                  r_trigger <= 1'b1;
                  r_state   <= ST_TRIGGER;
               end
            end
            ST_TRIGGER: begin
               if (w_wd_expired) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_ERROR;
               end else begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               // A completion arriving on the expiry cycle still counts.
               if (handler_done) begin
                  r_ops   <= r_ops + CNT_W'(1);
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_wd_expired) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_ERROR;
               end
            end
            ST_ERROR: begin
               if (clear_err) begin
                  r_err   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cur_op          = r_cur_op;
   assign handler_trigger = r_trigger;
   assign busy            = r_busy;
   assign err_timeout     = r_err;
   assign ops_done        = r_ops;

endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: two instances (watchdog off / 16-bit count and
// watchdog 8 / 4-bit count) checked every cycle against a behavioural model.
module tb_op_dispatcher;
   import op_dispatcher_pkg::*;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_WRDY  = 2;
   localparam int P_TRIG  = 3;
   localparam int P_WDONE = 4;
   localparam int P_ERR   = 5;

   typedef struct {
      int          ph;
      int unsigned age;
      Op_st        cur;
      bit          err;
      int unsigned ops;
   } mdl_t;

   logic clk;
   logic reset;
   Op_st op_in;
   logic op_in_valid, pause, handler_rdy, handler_done, clear_err;

   logic        a_rdy, a_trig, a_busy, a_err;
   Op_st        a_cur;
   logic [15:0] a_ops;
   logic        b_rdy, b_trig, b_busy, b_err;
   Op_st        b_cur;
   logic [3:0]  b_ops;

   int   checks   = 0;
   int   failures = 0;
   mdl_t ma, mb;
   bit   started  = 1'b0;

   op_dispatcher #(.TIMEOUT_CYCLES(0), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .op_in(op_in), .op_in_valid(op_in_valid),
      .op_in_rdy(a_rdy), .pause(pause), .cur_op(a_cur), .handler_trigger(a_trig),
      .handler_rdy(handler_rdy), .handler_done(handler_done), .busy(a_busy),
      .err_timeout(a_err), .clear_err(clear_err), .ops_done(a_ops));

   op_dispatcher #(.TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .op_in(op_in), .op_in_valid(op_in_valid),
      .op_in_rdy(b_rdy), .pause(pause), .cur_op(b_cur), .handler_trigger(b_trig),
      .handler_rdy(handler_rdy), .handler_done(handler_done), .busy(b_busy),
      .err_timeout(b_err), .clear_err(clear_err), .ops_done(b_ops));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Next model state from the sequencing rules: accept, one settle cycle,
   // wait for ready, one trigger cycle, wait for done; wait cycles are budgeted.
   function automatic mdl_t mstep(input mdl_t m, input int unsigned tmo);
      mdl_t n = m;
      if (reset) begin
         n.ph = P_IDLE; n.age = 0; n.cur = '0; n.err = 1'b0; n.ops = 0;
         return n;
      end
      case (m.ph)
         P_IDLE: if (op_in_valid && !pause) begin n.cur = op_in; n.ph = P_LOAD; end
         P_LOAD: begin n.ph = P_WRDY; n.age = 0; end
         P_WRDY, P_TRIG, P_WDONE: begin
            if (m.ph == P_WDONE && handler_done) begin
               n.ops = m.ops + 1; n.ph = P_IDLE;
            end else if (tmo != 0 && m.age + 1 >= tmo) begin
               n.err = 1'b1; n.ph = P_ERR;
            end else begin
               n.age = m.age + 1;
               if (m.ph == P_TRIG) n.ph = P_WDONE;
               else if (m.ph == P_WRDY && handler_rdy) n.ph = P_TRIG;
            end
         end
         P_ERR: if (clear_err) begin n.err = 1'b0; n.ph = P_IDLE; end
         default: n.ph = P_IDLE;
      endcase
      return n;
   endfunction

   task automatic cmp(input string t, input mdl_t m, input int unsigned cw,
                      input logic rdy, input logic trig, input logic bsy, input logic err,
                      input Op_st cur, input logic [63:0] ops);
      chk({t, "_op_in_rdy"}, 64'(rdy), 64'((m.ph == P_IDLE) && !pause));
      chk({t, "_trigger"}, 64'(trig), 64'(m.ph == P_TRIG));
      chk({t, "_busy"}, 64'(bsy), 64'(m.ph >= P_LOAD && m.ph <= P_WDONE));
      chk({t, "_err_timeout"}, 64'(err), 64'(m.err));
      chk({t, "_cur_op"}, 64'(cur), 64'(m.cur));
      chk({t, "_ops_done"}, ops, 64'(m.ops % (32'd1 << cw)));
   endtask

   always @(posedge clk) begin
      ma = mstep(ma, 0);
      mb = mstep(mb, 8);
      started = 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         cmp("a", ma, 16, a_rdy, a_trig, a_busy, a_err, a_cur, 64'(a_ops));
         cmp("b", mb, 4, b_rdy, b_trig, b_busy, b_err, b_cur, 64'(b_ops));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input Op_st op);
      op_in = op;
      handler_rdy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         op_in_valid  = (k == 0);
         handler_done = (k == 4);
         tick();
      end
      op_in_valid = 1'b0; handler_done = 1'b0;
   endtask

   initial begin
      Op_st seq[3];
      int   nt, idx, done_at, nd;
      int   acc_cyc[3];
      int   done_cyc[3];
      bit   flag;

      reset = 1'b1; op_in = '0; op_in_valid = 1'b0; pause = 1'b0;
      handler_rdy = 1'b0; handler_done = 1'b0; clear_err = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(a_busy), 0);
      chk("rst_ops", 64'(a_ops), 0);
      chk("rst_rdy", 64'(a_rdy), 1);
      chk("rst_err", 64'(b_err), 0);
      chk("rst_cur", 64'(a_cur), 0);
      tick();

      // Single op with ready held high, done in cycle 10.
      op_in = '{cmd: OP_CMD_G01, arg: 24'h000123}; handler_rdy = 1'b1;
      nt = 0; flag = 1'b1;
      for (int k = 0; k < 12; k++) begin
         op_in_valid = (k == 0); handler_done = (k == 10);
         @(negedge clk);
         if (k == 0) chk("t1_busy_c0", 64'(a_busy), 0);
         if (k == 3) chk("t1_trig_c3", 64'(a_trig), 1);
         if (k >= 1 && k <= 10) flag &= a_busy;
         nt += int'(a_trig);
         if (k == 11) begin
            chk("t1_rdy_c11", 64'(a_rdy), 1);
            chk("t1_ops", 64'(a_ops), 1);
            chk("t1_busy_c11", 64'(a_busy), 0);
            chk("t1_b_timeout", 64'(b_err), 1);
         end
         tick();
      end
      chk("t1_trig_count", 64'(nt), 1);
      chk("t1_busy_span", 64'(flag), 1);
      op_in_valid = 1'b0; handler_done = 1'b0; clear_err = 1'b1; tick();
      clear_err = 1'b0; tick();

      // Late readiness: ready rises in cycle 20.
      op_in = '{cmd: OP_CMD_G02, arg: 24'h000456};
      nt = 0; flag = 1'b0;
      for (int k = 0; k < 26; k++) begin
         op_in_valid = (k == 0); handler_rdy = (k >= 20); handler_done = (k == 23);
         @(negedge clk);
         if (k == 21) chk("t2_trig_c21", 64'(a_trig), 1);
         if (k < 21) flag |= a_trig;
         nt += int'(a_trig);
         tick();
      end
      chk("t2_trig_count", 64'(nt), 1);
      chk("t2_early_trig", 64'(flag), 0);
      chk("t2_ops", 64'(a_ops), 2);
      op_in_valid = 1'b0; handler_done = 1'b0; clear_err = 1'b1; tick();
      clear_err = 1'b0; tick();

      // Back-to-back: valid held, done two cycles after each trigger.
      seq[0] = '{cmd: OP_CMD_G01, arg: 24'h0A0001};
      seq[1] = '{cmd: OP_CMD_G03, arg: 24'h0B0002};
      seq[2] = '{cmd: OP_CMD_M02, arg: 24'h0C0003};
      idx = 0; nt = 0; nd = 0; done_at = -1; handler_rdy = 1'b1;
      for (int k = 0; k < 30; k++) begin
         handler_done = (k == done_at);
         op_in_valid  = (idx < 3);
         if (idx < 3) op_in = seq[idx];
         @(negedge clk);
         if (a_rdy && op_in_valid) begin acc_cyc[idx] = k; idx++; end
         if (a_trig) begin
            if (nt < 3) chk("t3_cur_op", 64'(a_cur), 64'(seq[nt]));
            nt++; done_at = k + 2;
         end
         if (handler_done && nd < 3) begin done_cyc[nd] = k; nd++; end
         tick();
      end
      handler_done = 1'b0; op_in_valid = 1'b0;
      chk("t3_trig_count", 64'(nt), 3);
      chk("t3_ops", 64'(a_ops), 5);
      chk("t3_b_ops", 64'(b_ops), 3);
      chk("t3_accept1", 64'(acc_cyc[1]), 64'(done_cyc[0] + 1));
      chk("t3_accept2", 64'(acc_cyc[2]), 64'(done_cyc[1] + 1));

      // Pause held with a pending op: nothing accepted.
      pause = 1'b1; op_in_valid = 1'b1; op_in = '{cmd: OP_CMD_G00, arg: 24'h000777};
      flag = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         flag |= a_rdy | a_busy | b_rdy | b_busy;
         tick();
      end
      chk("t4_paused", 64'(flag), 0);

      // Pause raised mid-op: current op completes, next op waits for release.
      seq[0] = '{cmd: OP_CMD_G01, arg: 24'h111111};
      seq[1] = '{cmd: OP_CMD_G02, arg: 24'h222222};
      flag = 1'b0;
      for (int k = 0; k < 37; k++) begin
         pause = (k >= 2 && k < 30);
         op_in_valid = (k <= 30);
         op_in = (k == 0) ? seq[0] : seq[1];
         handler_done = (k == 8 || k == 35);
         @(negedge clk);
         if (k >= 9 && k < 30) flag |= a_busy;
         if (k == 9) chk("t4_first_done", 64'(a_ops), 6);
         if (k == 31) begin
            chk("t4_resumed", 64'(a_busy), 1);
            chk("t4_cur_op", 64'(a_cur), 64'(seq[1]));
         end
         if (k == 36) chk("t4_second_done", 64'(a_ops), 7);
         tick();
      end
      chk("t4_held", 64'(flag), 0);
      pause = 1'b0; op_in_valid = 1'b0; handler_done = 1'b0;

      // Watchdog on instance b: handler never done.
      op_in = '{cmd: OP_CMD_G01, arg: 24'h0000EE};
      for (int k = 0; k < 20; k++) begin
         op_in_valid  = (k == 0) || (k >= 11 && k < 14);
         clear_err    = (k == 16);
         handler_done = (k == 18);
         @(negedge clk);
         if (k == 9)  chk("t5_err_c9", 64'(b_err), 0);
         if (k == 10) begin chk("t5_err_c10", 64'(b_err), 1); chk("t5_busy_c10", 64'(b_busy), 0); end
         if (k == 12) chk("t5_no_accept", 64'(b_rdy), 0);
         if (k == 17) begin
            chk("t5_cleared", 64'(b_err), 0);
            chk("t5_idle_rdy", 64'(b_rdy), 1);
            chk("t5_ops_kept", 64'(b_ops), 5);
         end
         if (k == 19) begin chk("t5_stale_done", 64'(b_ops), 5); chk("t5_a_ops", 64'(a_ops), 8); end
         tick();
      end
      clear_err = 1'b0; handler_done = 1'b0; op_in_valid = 1'b0;

      // Done on the expiry cycle wins over the timeout.
      for (int k = 0; k < 11; k++) begin
         op_in_valid = (k == 0); handler_done = (k == 9);
         @(negedge clk);
         if (k == 10) begin
            chk("t5b_no_err", 64'(b_err), 0);
            chk("t5b_ops", 64'(b_ops), 6);
            chk("t5b_a_ops", 64'(a_ops), 9);
         end
         tick();
      end
      handler_done = 1'b0; op_in_valid = 1'b0;

      // Reset in WAIT_DONE, then stale dones in IDLE and LOAD.
      op_in = '{cmd: OP_CMD_G03, arg: 24'h00ABCD};
      for (int k = 0; k < 15; k++) begin
         op_in_valid  = (k == 0) || (k == 8);
         reset        = (k == 5);
         handler_done = (k == 7) || (k == 9) || (k == 13);
         @(negedge clk);
         if (k == 6) begin
            chk("t6_rst_busy", 64'(a_busy), 0);
            chk("t6_rst_trig", 64'(a_trig), 0);
            chk("t6_rst_ops", 64'(a_ops), 0);
            chk("t6_rst_cur", 64'(a_cur), 0);
            chk("t6_rst_rdy", 64'(a_rdy), 1);
         end
         if (k == 12) chk("t6_stale_ignored", 64'(a_ops), 0);
         if (k == 14) chk("t6_done", 64'(a_ops), 1);
         tick();
      end
      reset = 1'b0; handler_done = 1'b0; op_in_valid = 1'b0;

      // Wrap of the 4-bit counter on instance b.
      repeat (14) do_op('{cmd: OP_CMD_G00, arg: 24'h000001});
      @(negedge clk);
      chk("wrap_pre", 64'(b_ops), 15);
      tick();
      do_op('{cmd: OP_CMD_G00, arg: 24'h000002});
      @(negedge clk);
      chk("wrap_zero", 64'(b_ops), 0);
      chk("wrap_a_ops", 64'(a_ops), 16);
      tick();

      // Randomized traffic, including unknown cmds, pauses, clears and resets.
      for (int k = 0; k < 4000; k++) begin
         op_in.cmd    = 8'($urandom_range(0, 255));
         op_in.arg    = 24'($urandom);
         op_in_valid  = ($urandom_range(0, 1) == 0);
         pause        = ($urandom_range(0, 4) == 0);
         handler_rdy  = ($urandom_range(0, 9) < 6);
         handler_done = ($urandom_range(0, 9) < 3);
         clear_err    = ($urandom_range(0, 9) == 0);
         reset        = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; op_in_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
